multiexp_pnt_scl_feeder: RTL

- Source end of the multiexp core's scalar/point input stream.
- Host/DMA loads N (scalar, G2 point) pairs into an internal buffer once.
- The block then replays the pairs in order 0..N-1, NUM_REP times, as one wide AXI-stream beat per pair. The core consumes each pass once per key bit.
- Sits between the host load path and one multiexp_fp2_core instance; also drives the core's i_num_in.

---
 rtl/multiexp_pnt_scl_feeder_if.sv | 18 +
 rtl/multiexp_pnt_scl_feeder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/multiexp_pnt_scl_feeder_if.sv
// Valid/ready stream bundle for wide multiexp beats (scalar/point pairs) with sop/eop framing
// and a side control field. The source/sink modports have master/slave aliases.
interface if_axi_stream #(
    parameter int DAT_BITS = 32,
    parameter int CTL_BITS = 16
);
    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;

    modport source (output val, sop, eop, dat, ctl, input rdy);
    modport sink   (input val, sop, eop, dat, ctl, output rdy);
    modport master (output val, sop, eop, dat, ctl, input rdy);
    modport slave  (input val, sop, eop, dat, ctl, output rdy);
endinterface

// File: rtl/multiexp_pnt_scl_feeder.sv
// Buffers N (scalar, G2 point) pairs once, then replays them NUM_REP times to the multiexp core.
// Optional: MULTIEXP_FEEDER_STALL_CNT_EN adds o_stall_cnt (valid-but-not-ready cycles while streaming).
//
// state  | meaning
// IDLE   | loader ready; waiting for the first load beat or i_start
// LOAD   | taking pairs into the buffer until eop
// STREAM | replaying the buffer; loader held off
module multiexp_pnt_scl_feeder #(
    parameter type FE_TYPE  = logic [380:0],
    parameter type FP2_TYPE = logic [4*381-1:0],
    parameter int  CTL_BITS = 16,
    parameter int  NUM_MAX  = 1024,
    parameter int  DAT_BITS = $bits(FE_TYPE) + $bits(FP2_TYPE)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    if_axi_stream.sink          i_load_if,
    if_axi_stream.source        o_pnt_scl_if,
    input  logic                i_start,
    input  logic [15:0]         i_num_rep,
    input  logic [CTL_BITS-1:0] i_ctl,
    output logic [63:0]         o_num_in,
    output logic                o_busy,
    output logic                o_done
`ifdef MULTIEXP_FEEDER_STALL_CNT_EN
    ,
    output logic [31:0]         o_stall_cnt
`endif
);
    localparam int AW = $clog2(NUM_MAX);
    localparam int CW = AW + 1;
    localparam int FW = DAT_BITS + 3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    logic [1:0]          r_state;
    logic                r_load_rdy;
    logic [CW-1:0]       r_num_in;
    logic [AW-1:0]       r_rd_ptr;
    logic [15:0]         r_pass;
    logic [15:0]         r_num_rep;
    logic                r_rd_done;
    logic [CTL_BITS-1:0] r_ctl;
    logic                r_done;

    logic [DAT_BITS-1:0] r_mem [NUM_MAX];
    logic [DAT_BITS-1:0] r_rd_dat;
    logic                r_rd_vld;
    logic [2:0]          r_rd_flg;

    // Prefetch FIFO entry = {last, eop, sop, dat}; r_f0 is the head
    logic [FW-1:0]       r_f0;
    logic [FW-1:0]       r_f1;
    logic [1:0]          r_cnt;

    logic                w_load_hs;
    logic                w_full;
    logic                w_wr_en;
    logic [AW-1:0]       w_wr_addr;
    logic                w_start_ok;
    logic                w_out_val;
    logic                w_pop;
    logic [2:0]          w_occ;
    logic                w_rd_en;
    logic                w_rd_eop;
    logic                w_rd_last_pass;
    logic                w_last_hs;
    logic [FW-1:0]       w_push_ent;
    logic                w_unused_load;

    assign w_load_hs      = i_load_if.val & r_load_rdy;
    assign w_full         = (r_num_in == CW'(NUM_MAX));
    assign w_wr_en        = w_load_hs & ((r_state == ST_IDLE) | ((r_state == ST_LOAD) & ~w_full));
    assign w_wr_addr      = (r_state == ST_IDLE) ? '0 : r_num_in[AW-1:0];
    assign w_start_ok     = i_start & (r_state == ST_IDLE) & ~w_load_hs
                            & (r_num_in != '0) & (i_num_rep != 16'd0);
    assign w_out_val      = (r_cnt != 2'd0);
    assign w_pop          = w_out_val & o_pnt_scl_if.rdy;
    assign w_last_hs      = w_pop & r_f0[FW-1];
    assign w_rd_eop       = ({1'b0, r_rd_ptr} == (r_num_in - CW'(1)));
    assign w_rd_last_pass = (r_pass == (r_num_rep - 16'd1));
    assign w_push_ent     = {r_rd_flg, r_rd_dat};

    // Entries already held plus the one landing this cycle; a new read lands one cycle later
    assign w_occ   = {1'b0, r_cnt} + {2'b00, r_rd_vld};
    assign w_rd_en = (r_state == ST_STREAM) & ~r_rd_done
                     & ((w_occ <= 3'd1) | ((w_occ == 3'd2) & w_pop));

    assign w_unused_load = ^{i_load_if.sop, i_load_if.ctl};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_load_rdy <= 1'b0;
            r_num_in   <= '0;
            r_rd_ptr   <= '0;
            r_pass     <= '0;
            r_num_rep  <= '0;
            r_rd_done  <= 1'b0;
            r_ctl      <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_load_rdy <= 1'b1;
                    if (w_load_hs) begin
                        r_num_in <= CW'(1);
                        if (!i_load_if.eop)
                            r_state <= ST_LOAD;
                    end else if (w_start_ok) begin
                        r_state    <= ST_STREAM;
                        r_load_rdy <= 1'b0;
                        r_rd_ptr   <= '0;
                        r_pass     <= '0;
                        r_rd_done  <= 1'b0;
                        r_num_rep  <= i_num_rep;
                        r_ctl      <= i_ctl;
                    end
                end
                ST_LOAD: begin
                    if (w_load_hs) begin
                        if (!w_full)
                            r_num_in <= r_num_in + CW'(1);
                        if (i_load_if.eop)
                            r_state <= ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    if (w_rd_en) begin
                        if (w_rd_eop) begin
                            r_rd_ptr <= '0;
                            r_pass   <= r_pass + 16'd1;
                            if (w_rd_last_pass)
                                r_rd_done <= 1'b1;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + AW'(1);
                        end
                    end
                    if (w_last_hs) begin
                        r_state    <= ST_IDLE;
                        r_done     <= 1'b1;
                        r_load_rdy <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_load_rdy <= 1'b0;
                end
            endcase
        end
    end

    // Buffer contents are not reset
    always_ff @(posedge i_clk) begin
        if (w_wr_en)
            r_mem[w_wr_addr] <= i_load_if.dat;
        if (w_rd_en)
            r_rd_dat <= r_mem[r_rd_ptr];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_vld <= 1'b0;
            r_rd_flg <= '0;
        end else begin
            r_rd_vld <= w_rd_en;
            if (w_rd_en)
                r_rd_flg <= {w_rd_eop & w_rd_last_pass, w_rd_eop, (r_rd_ptr == '0)};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_f0  <= '0;
            r_f1  <= '0;
            r_cnt <= 2'd0;
        end else begin
            case ({r_rd_vld, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0)
                        r_f0 <= w_push_ent;
                    else
                        r_f1 <= w_push_ent;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_f0  <= r_f1;
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_f0 <= w_push_ent;
                    end else begin
                        r_f0 <= r_f1;
                        r_f1 <= w_push_ent;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MULTIEXP_FEEDER_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_stall_cnt <= '0;
        else if (w_start_ok)
            r_stall_cnt <= '0;
        else if ((r_state == ST_STREAM) && w_out_val && !o_pnt_scl_if.rdy && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

    assign i_load_if.rdy    = r_load_rdy;
    assign o_pnt_scl_if.val = w_out_val;
    assign o_pnt_scl_if.sop = w_out_val & r_f0[DAT_BITS];
    assign o_pnt_scl_if.eop = w_out_val & r_f0[DAT_BITS+1];
    assign o_pnt_scl_if.dat = r_f0[DAT_BITS-1:0];
    assign o_pnt_scl_if.ctl = r_ctl;
    assign o_num_in         = 64'(r_num_in);
    assign o_busy           = (r_state != ST_IDLE);
    assign o_done           = r_done;
endmodule
